// File: rtl/clk_div_pkg.sv
// Display-path clock constants shared by the pixel pipeline blocks.
package clk_div_pkg;

  localparam int SYS_CLK_HZ    = 100_000_000;
  localparam int PIX_CLK_HZ    = 25_000_000;
  localparam int CLK_DIV_RATIO = SYS_CLK_HZ / PIX_CLK_HZ;

  function automatic int half_div(input int div);
    return div / 2;
  endfunction

endpackage

// File: rtl/clk_div_if.sv
// Divided-clock outputs: clk_d and its clk-domain enable pulse clk_en.
interface clk_div_if;

  logic clk_d;
  logic clk_en;

  modport master (output clk_d, output clk_en);
  modport slave  (input  clk_d, input  clk_en);

endinterface

// File: rtl/clk_div.sv
// Fixed-ratio divider: clk_d with period DIV clk cycles, clk_en high for one clk cycle at each clk_d rise.
// First rise lands on the DIV-th posedge after reset release; odd DIV can be balanced with a negedge flop.
module clk_div
  import clk_div_pkg::*;
#(
  parameter int DIV         = CLK_DIV_RATIO,
  parameter bit ODD_BALANCE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  clk_div_if.master  div_if
);

  localparam int              HALF = half_div(DIV);
  localparam int              CW   = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0]   LAST = CW'(DIV - 1);
  localparam logic [CW-1:0]   FALL = CW'(HALF - 1);
  localparam bit              BAL  = ODD_BALANCE && ((DIV % 2) == 1);

  if (DIV < 2) begin : g_bad_div
    $error("clk_div: DIV must be at least 2");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pos_q, pos_d;
  logic          en_q,  en_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    en_d  = (cnt_q == LAST);
    pos_d = pos_q;
    if (cnt_q == LAST) begin
      pos_d = 1'b1;
    end else if (cnt_q == FALL) begin
      pos_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      pos_q <= 1'b0;
      en_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pos_q <= pos_d;
      en_q  <= en_d;
    end
  end

  // The negedge copy stretches the high phase by half a clk period for odd ratios.
  if (BAL) begin : g_balanced
    logic neg_q;
    always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
        neg_q <= 1'b0;
      end else begin
        neg_q <= pos_q;
      end
    end
    assign div_if.clk_d = pos_q | neg_q;
  end else begin : g_posedge_only
    assign div_if.clk_d = pos_q;
  end

  assign div_if.clk_en = en_q;

endmodule

// File: tb/tb_clk_div.sv
// Bench for clk_div: four ratios side by side, table sequence, async reset corners, random resets.
module tb_clk_div;
  import clk_div_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   k;

  clk_div_if if4 ();
  clk_div_if if2 ();
  clk_div_if if5u ();
  clk_div_if if5b ();

  clk_div #(.DIV(CLK_DIV_RATIO), .ODD_BALANCE(1'b1)) u_div4  (.clk(clk), .reset(rst), .div_if(if4));
  clk_div #(.DIV(2),             .ODD_BALANCE(1'b1)) u_div2  (.clk(clk), .reset(rst), .div_if(if2));
  clk_div #(.DIV(5),             .ODD_BALANCE(1'b0)) u_div5u (.clk(clk), .reset(rst), .div_if(if5u));
  clk_div #(.DIV(5),             .ODD_BALANCE(1'b1)) u_div5b (.clk(clk), .reset(rst), .div_if(if5b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // k counts clk posedges since reset release; phase = k mod div within a period.
  function automatic bit high_after_pos(input int div, input int kk);
    return (kk >= div) && ((kk % div) < (div / 2));
  endfunction

  // Balanced odd ratio: high for div/2 whole cycles plus the first half of the next one.
  function automatic bit exp_d(input int div, input bit bal, input int kk, input bit second);
    if (bal && (div % 2 == 1) && !second)
      return high_after_pos(div, kk) || high_after_pos(div, kk - 1);
    return high_after_pos(div, kk);
  endfunction

  function automatic bit exp_en(input int div, input int kk);
    return (kk >= div) && ((kk % div) == 0);
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (k=%0d t=%0t)", name, act, exp, k, $time);
    end
  endtask

  task automatic check_all(input bit second);
    chk("div4_clk_d",   if4.clk_d,   exp_d(4, 1'b1, k, second));
    chk("div4_clk_en",  if4.clk_en,  exp_en(4, k));
    chk("div2_clk_d",   if2.clk_d,   exp_d(2, 1'b1, k, second));
    chk("div2_clk_en",  if2.clk_en,  exp_en(2, k));
    chk("div5u_clk_d",  if5u.clk_d,  exp_d(5, 1'b0, k, second));
    chk("div5u_clk_en", if5u.clk_en, exp_en(5, k));
    chk("div5b_clk_d",  if5b.clk_d,  exp_d(5, 1'b1, k, second));
    chk("div5b_clk_en", if5b.clk_en, exp_en(5, k));
  endtask

  // One clk cycle: sample 1 ns after the posedge and 1 ns after the negedge.
  task automatic step();
    @(posedge clk);
    if (!rst) k++;
    #1 check_all(1'b0);
    @(negedge clk);
    #1 check_all(1'b1);
  endtask

  task automatic assert_reset();
    rst = 1'b1;
    k   = 0;
  endtask

  typedef struct {
    int k;
    bit d4;
    bit en4;
    bit d2;
    bit d5u;
    bit d5b;
  } vec_t;

  vec_t tbl [10];
  int   cnt4, cnt2, cnt5;

  initial begin
    checks   = 0;
    failures = 0;
    k        = 0;
    rst      = 1'b1;

    tbl[0] = '{1,  0, 0, 0, 0, 0};
    tbl[1] = '{2,  0, 0, 1, 0, 0};
    tbl[2] = '{3,  0, 0, 0, 0, 0};
    tbl[3] = '{4,  1, 1, 1, 0, 0};
    tbl[4] = '{5,  1, 0, 0, 1, 1};
    tbl[5] = '{6,  0, 0, 1, 1, 1};
    tbl[6] = '{7,  0, 0, 0, 0, 1};
    tbl[7] = '{8,  1, 1, 1, 0, 0};
    tbl[8] = '{9,  1, 0, 0, 0, 0};
    tbl[9] = '{10, 0, 0, 1, 1, 1};

    // Reset held for three cycles; everything low.
    for (int i = 0; i < 3; i++) step();
    chk("reset_clk_d", if4.clk_d, 1'b0);
    chk("reset_clk_en", if4.clk_en, 1'b0);

    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      k++;
      #1;
      chk("tbl_k", (k == tbl[i].k) ? 1'b1 : 1'b0, 1'b1);
      chk("tbl_d4",  if4.clk_d,  tbl[i].d4);
      chk("tbl_en4", if4.clk_en, tbl[i].en4);
      chk("tbl_d2",  if2.clk_d,  tbl[i].d2);
      chk("tbl_d5u", if5u.clk_d, tbl[i].d5u);
      chk("tbl_d5b", if5b.clk_d, tbl[i].d5b);
      check_all(1'b0);
      @(negedge clk);
      #1 check_all(1'b1);
    end

    // Async reset in the middle of the DIV=4 high phase, away from any edge.
    for (int i = 0; i < 8 && (k % 4) != 1; i++) step();
    chk("midhigh_pre_d4", if4.clk_d, 1'b1);
    #1 assert_reset();
    #1;
    chk("midhigh_async_d4",  if4.clk_d,  1'b0);
    chk("midhigh_async_en4", if4.clk_en, 1'b0);
    check_all(1'b1);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midhigh_no_early_rise", if4.clk_d, 1'b0);
    end
    @(posedge clk);
    k++;
    #1;
    chk("midhigh_rise_at_4", if4.clk_d, 1'b1);
    chk("midhigh_en_at_4",   if4.clk_en, 1'b1);
    @(negedge clk);
    #1 check_all(1'b1);

    // Async reset while the clk_en pulse is high.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      k++;
      #1 check_all(1'b0);
      if ((k % 4) == 0) break;
      @(negedge clk);
      #1 check_all(1'b1);
    end
    chk("enpulse_pre_en4", if4.clk_en, 1'b1);
    #2 assert_reset();
    #1;
    chk("enpulse_truncated_en4", if4.clk_en, 1'b0);
    chk("enpulse_truncated_d4",  if4.clk_d,  1'b0);
    step();
    rst = 1'b0;
    cnt4 = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (if4.clk_en) cnt4++;
    end
    chk("enpulse_no_extra_pulse", (cnt4 == 0) ? 1'b1 : 1'b0, 1'b1);
    @(posedge clk);
    k++;
    #1 chk("enpulse_first_at_4", if4.clk_en, 1'b1);
    @(negedge clk);
    #1 check_all(1'b1);

    // 40 cycles from a fresh release: pulse counts per ratio.
    assert_reset();
    step();
    rst = 1'b0;
    cnt4 = 0; cnt2 = 0; cnt5 = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      k++;
      #1;
      check_all(1'b0);
      if (if4.clk_en)  cnt4++;
      if (if2.clk_en)  cnt2++;
      if (if5u.clk_en) cnt5++;
      @(negedge clk);
      #1 check_all(1'b1);
    end
    chk("count_en4_is_10", (cnt4 == 10) ? 1'b1 : 1'b0, 1'b1);
    chk("count_en2_is_20", (cnt2 == 20) ? 1'b1 : 1'b0, 1'b1);
    chk("count_en5_is_8",  (cnt5 == 8)  ? 1'b1 : 1'b0, 1'b1);

    // Random run lengths with asynchronous resets dropped between edges.
    for (int it = 0; it < 25; it++) begin
      int run;
      run = $urandom_range(1, 25);
      for (int i = 0; i < run; i++) step();
      #($urandom_range(1, 2));
      assert_reset();
      #1 check_all(1'b1);
      run = $urandom_range(1, 3);
      for (int i = 0; i < run; i++) step();
      rst = 1'b0;
    end
    for (int i = 0; i < 12; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
